// File: rtl/uart_txfifo.sv
// Transmit byte queue for the uart: power-of-two circular FIFO filled from the CPU bus,
// drained one byte at a time into the transmitter whenever it reports idle.
module uart_txfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  uart_wr,
    output logic [7:0]            uart_data,
    input  logic                  uart_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_full, w_empty, w_push, w_drop, w_pop;
    logic                r_overflow, r_uart_wr;
    logic [7:0]          r_uart_data;
    state_t              r_state, w_state_nxt;

    // One extra pointer bit distinguishes full from empty when the indices match.
    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == FULL_CNT);
    assign w_empty = (w_count == '0);
    assign w_push  = wr & ~w_full;
    assign w_drop  = wr & w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !uart_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (!uart_busy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_uart_wr   <= 1'b0;
            r_uart_data <= 8'h00;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) begin
                r_rptr      <= r_rptr + PTR_ONE;
                r_uart_data <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
            end
            // Strobe is high exactly while the FSM sits in ISSUE.
            r_uart_wr <= w_pop;
            if (w_drop)            r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = w_count;
    assign overflow  = r_overflow;
    assign uart_wr   = r_uart_wr;
    assign uart_data = r_uart_data;
endmodule
